// File: rtl/nf10_encap_input_arbiter.sv
// nf10_encap_input_arbiter
//   Packet-granular round-robin arbiter sharing one nf10_encap AXI-Stream
//   slave port between C_NUM_INPUTS upstream streams. One whole packet is
//   forwarded from the granted input; the grant is held until tlast.
//   Optional build macro ENCAP_ARB_SRC_STAMP_EN: overwrite tuser[23:16] with
//   the NetFPGA MAC source-port one-hot of the granted input (max 4 inputs).

// Per-input gate: drives its stream onto the shared bus only when selected.
module nf10_encap_arb_lane #(
    parameter int DW = 256,
    parameter int UW = 128
) (
    input  logic            sel,
    input  logic [DW-1:0]   s_tdata,
    input  logic [DW/8-1:0] s_tstrb,
    input  logic [UW-1:0]   s_tuser,
    input  logic            s_tvalid,
    input  logic            s_tlast,
    input  logic            m_tready,
    output logic            s_tready,
    output logic [DW-1:0]   g_tdata,
    output logic [DW/8-1:0] g_tstrb,
    output logic [UW-1:0]   g_tuser,
    output logic            g_tvalid,
    output logic            g_tlast
);

    // Zero everything when unselected so the top can OR-reduce the lanes.
    always_comb begin
        g_tdata  = sel ? s_tdata : '0;
        g_tstrb  = sel ? s_tstrb : '0;
        g_tuser  = sel ? s_tuser : '0;
        g_tvalid = sel & s_tvalid;
        g_tlast  = sel & s_tlast;
        s_tready = sel & m_tready;
    end

endmodule

module nf10_encap_input_arbiter #(
    parameter int C_NUM_INPUTS  = 4,
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128
) (
    input  logic                                  axi_aclk,
    input  logic                                  axi_resetn,
    input  logic [C_NUM_INPUTS*C_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [C_NUM_INPUTS*C_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [C_NUM_INPUTS*C_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [C_NUM_INPUTS-1:0]               s_axis_tvalid,
    input  logic [C_NUM_INPUTS-1:0]               s_axis_tlast,
    output logic [C_NUM_INPUTS-1:0]               s_axis_tready,
    output logic [C_DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0]             m_axis_tstrb,
    output logic [C_TUSER_WIDTH-1:0]              m_axis_tuser,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic                                  busy,
    output logic [2:0]                            grant
);

    localparam int SW = C_DATA_WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [2:0] rr_ptr;
    logic [2:0] winner;
    logic       req_any;
    logic [3:0] scan_idx;
    logic       pkt_done;

    logic [C_NUM_INPUTS-1:0]                    sel;
    logic [C_NUM_INPUTS-1:0][C_DATA_WIDTH-1:0]  lane_tdata;
    logic [C_NUM_INPUTS-1:0][SW-1:0]            lane_tstrb;
    logic [C_NUM_INPUTS-1:0][C_TUSER_WIDTH-1:0] lane_tuser;
    logic [C_NUM_INPUTS-1:0]                    lane_tvalid;
    logic [C_NUM_INPUTS-1:0]                    lane_tlast;

    if (C_NUM_INPUTS < 2 || C_NUM_INPUTS > 8) begin : g_bad_num_inputs
        $error("nf10_encap_input_arbiter: C_NUM_INPUTS must be 2..8");
    end
    if (C_TUSER_WIDTH < 32) begin : g_bad_tuser_width
        $error("nf10_encap_input_arbiter: C_TUSER_WIDTH must be >= 32");
    end
`ifdef ENCAP_ARB_SRC_STAMP_EN
    if (C_NUM_INPUTS > 4) begin : g_bad_stamp_inputs
        $error("nf10_encap_input_arbiter: source stamping supports at most 4 inputs");
    end
`endif

    for (genvar i = 0; i < C_NUM_INPUTS; i++) begin : g_lane
        assign sel[i] = (state == PKT) && (grant == 3'(i));
        nf10_encap_arb_lane #(.DW(C_DATA_WIDTH), .UW(C_TUSER_WIDTH)) u_lane (
            .sel      (sel[i]),
            .s_tdata  (s_axis_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
            .s_tstrb  (s_axis_tstrb[i*SW +: SW]),
            .s_tuser  (s_axis_tuser[i*C_TUSER_WIDTH +: C_TUSER_WIDTH]),
            .s_tvalid (s_axis_tvalid[i]),
            .s_tlast  (s_axis_tlast[i]),
            .m_tready (m_axis_tready),
            .s_tready (s_axis_tready[i]),
            .g_tdata  (lane_tdata[i]),
            .g_tstrb  (lane_tstrb[i]),
            .g_tuser  (lane_tuser[i]),
            .g_tvalid (lane_tvalid[i]),
            .g_tlast  (lane_tlast[i])
        );
    end

    // Round-robin scan from rr_ptr; walking k downwards lets the closest
    // requester overwrite farther ones, so no early-exit is needed.
    always_comb begin
        req_any  = 1'b0;
        winner   = rr_ptr;
        scan_idx = '0;
        for (int k = C_NUM_INPUTS - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr} + 4'(k);
            if (scan_idx >= 4'(C_NUM_INPUTS))
                scan_idx = scan_idx - 4'(C_NUM_INPUTS);
            for (int i = 0; i < C_NUM_INPUTS; i++) begin
                if (scan_idx == 4'(i) && s_axis_tvalid[i]) begin
                    req_any = 1'b1;
                    winner  = 3'(i);
                end
            end
        end
    end

    // State register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next state: a request opens a packet, an accepted tlast closes it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_any)  state_nxt = PKT;
            PKT:     if (pkt_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output mux: OR of the gated lanes (only the granted lane is non-zero in PKT).
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        for (int i = 0; i < C_NUM_INPUTS; i++) begin
            m_axis_tdata  = m_axis_tdata  | lane_tdata[i];
            m_axis_tstrb  = m_axis_tstrb  | lane_tstrb[i];
            m_axis_tuser  = m_axis_tuser  | lane_tuser[i];
            m_axis_tvalid = m_axis_tvalid | lane_tvalid[i];
            m_axis_tlast  = m_axis_tlast  | lane_tlast[i];
        end
`ifdef ENCAP_ARB_SRC_STAMP_EN
        // MAC source ports sit on the even bits of the source-port byte.
        if (state == PKT)
            m_axis_tuser[23:16] = 8'h01 << {grant[1:0], 1'b0};
`endif
    end

    assign pkt_done = (state == PKT) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Registered grant/busy and the round-robin pointer.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            grant  <= '0;
            rr_ptr <= '0;
            busy   <= 1'b0;
        end else begin
            if (state == IDLE && req_any)
                grant <= winner;
            if (pkt_done)
                rr_ptr <= (grant == 3'(C_NUM_INPUTS - 1)) ? 3'd0 : grant + 3'd1;
            busy <= (state_nxt == PKT);
        end
    end

endmodule

// File: tb/tb_nf10_encap_input_arbiter.sv
// tb_nf10_encap_input_arbiter
//   Directed scenarios followed by a randomized phase; every cycle the DUT
//   outputs are compared against a packet-level round-robin reference model.
module tb_nf10_encap_input_arbiter;

    localparam int N  = 4;
    localparam int DW = 256;
    localparam int SW = DW / 8;
    localparam int UW = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N*DW-1:0]   s_tdata;
    logic [N*SW-1:0]   s_tstrb;
    logic [N*UW-1:0]   s_tuser;
    logic [N-1:0]      s_tvalid;
    logic [N-1:0]      s_tlast;
    logic [N-1:0]      s_tready;
    logic [DW-1:0]     m_tdata;
    logic [SW-1:0]     m_tstrb;
    logic [UW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic              busy;
    logic [2:0]        grant;

    int n_chk = 0;
    int n_err = 0;

    // reference model: packet owner, last grant, round-robin start point
    bit           m_pkt;
    int           m_gnt;
    int           m_ptr;
    logic [N-1:0] acc;

    // random source state
    bit hold [N];
    int left [N];

    always #5 clk = ~clk;

    nf10_encap_input_arbiter #(.C_NUM_INPUTS(N), .C_DATA_WIDTH(DW), .C_TUSER_WIDTH(UW)) dut (
        .axi_aclk      (clk),
        .axi_resetn    (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tstrb  (s_tstrb),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tstrb  (m_tstrb),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .busy          (busy),
        .grant         (grant)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_d();
        logic [DW-1:0] r;
        for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] rnd_u();
        logic [UW-1:0] r;
        for (int k = 0; k < UW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic drive(input int i, input logic v, input logic l,
                         input logic [DW-1:0] d, input logic [SW-1:0] s, input logic [UW-1:0] u);
        s_tvalid[i]         = v;
        s_tlast[i]          = l;
        s_tdata[i*DW +: DW] = d;
        s_tstrb[i*SW +: SW] = s;
        s_tuser[i*UW +: UW] = u;
    endtask

    task automatic clear_inputs();
        s_tdata  = '0;
        s_tstrb  = '0;
        s_tuser  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
    endtask

    task automatic model_reset();
        m_pkt = 0;
        m_gnt = 0;
        m_ptr = 0;
        acc   = '0;
    endtask

    // Expected outputs: idle drives nothing; a packet owner is passed straight through.
    task automatic check_outputs();
        logic [N-1:0]  e_rdy;
        logic          e_v, e_l;
        logic [DW-1:0] e_d;
        logic [SW-1:0] e_s;
        logic [UW-1:0] e_u;
        e_rdy = '0; e_v = 0; e_l = 0; e_d = '0; e_s = '0; e_u = '0;
        if (m_pkt) begin
            e_v = s_tvalid[m_gnt];
            e_l = s_tlast[m_gnt];
            e_d = s_tdata[m_gnt*DW +: DW];
            e_s = s_tstrb[m_gnt*SW +: SW];
            e_u = s_tuser[m_gnt*UW +: UW];
`ifdef ENCAP_ARB_SRC_STAMP_EN
            e_u[23:16] = 8'(1 << (2 * m_gnt));
`endif
            e_rdy[m_gnt] = m_tready;
        end
        chk("m_tvalid", DW'(m_tvalid), DW'(e_v));
        chk("m_tlast",  DW'(m_tlast),  DW'(e_l));
        chk("m_tdata",  m_tdata,       e_d);
        chk("m_tstrb",  DW'(m_tstrb),  DW'(e_s));
        chk("m_tuser",  DW'(m_tuser),  DW'(e_u));
        chk("s_tready", DW'(s_tready), DW'(e_rdy));
        chk("busy",     DW'(busy),     DW'(m_pkt));
        chk("grant",    DW'(grant),    DW'(m_gnt));
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_update();
        acc = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_pkt) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (s_tvalid[j]) begin
                    m_gnt = j;
                    m_pkt = 1;
                    break;
                end
            end
        end else if (s_tvalid[m_gnt] && m_tready) begin
            acc[m_gnt] = 1'b1;
            if (s_tlast[m_gnt]) begin
                m_pkt = 0;
                m_ptr = (m_gnt + 1) % N;
            end
        end
    endtask

    // One clock: check, step model, return at the next falling edge.
    task automatic tick();
        #1;
        check_outputs();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    // AXI-legal random sources: a beat once shown is held until accepted.
    task automatic src_step();
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                hold[i] = 0;
                left[i]--;
            end
            if (!hold[i]) begin
                if ($urandom_range(0, 3) != 0) begin
                    if (left[i] == 0) left[i] = $urandom_range(1, 4);
                    drive(i, 1'b1, left[i] == 1, rnd_d(), SW'($urandom), rnd_u());
                    hold[i] = 1;
                end else begin
                    drive(i, 1'b0, 1'b0, rnd_d(), SW'($urandom), rnd_u());
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] da, db, dc, dx;
        logic [UW-1:0] u_exp;
        int            gseq [5];
        int            gi;

        rst_n    = 1'b0;
        m_tready = 1'b0;
        clear_inputs();
        model_reset();

        // reset held for 50 cycles
        repeat (50) tick();
        rst_n = 1'b1;
        #1;
        chk("rst_busy",   DW'(busy),     DW'(0));
        chk("rst_grant",  DW'(grant),    DW'(0));
        chk("rst_tvalid", DW'(m_tvalid), DW'(0));
        chk("rst_tready", DW'(s_tready), DW'(0));
        tick();

        // two-beat packet on input 0
        m_tready = 1'b1;
        drive(0, 1'b1, 1'b0, DW'(256'h1111), 32'hFFFFFFFF, 128'h0104AAAA);
        #1;
        chk("p0_bubble_tvalid", DW'(m_tvalid), DW'(0));
        tick();
`ifdef ENCAP_ARB_SRC_STAMP_EN
        u_exp = 128'h0101AAAA;
`else
        u_exp = 128'h0104AAAA;
`endif
        #1;
        chk("p0_b1_tvalid", DW'(m_tvalid), DW'(1));
        chk("p0_b1_tuser",  DW'(m_tuser),  DW'(u_exp));
        chk("p0_b1_tstrb",  DW'(m_tstrb),  DW'(32'hFFFFFFFF));
        chk("p0_b1_data",   m_tdata,       DW'(256'h1111));
        chk("p0_busy",      DW'(busy),     DW'(1));
        tick();
        drive(0, 1'b1, 1'b1, DW'(256'h2222), 32'h000003FF, 128'h0);
        #1;
        chk("p0_b2_tstrb", DW'(m_tstrb), DW'(32'h000003FF));
        chk("p0_b2_tlast", DW'(m_tlast), DW'(1));
        tick();
        clear_inputs();
        #1;
        chk("p0_busy_fall", DW'(busy), DW'(0));
        // rr_ptr must now be 1: inputs 0 and 1 both request, 1 wins
        drive(0, 1'b1, 1'b1, DW'(256'hA0), '1, '0);
        drive(1, 1'b1, 1'b1, DW'(256'hA1), '1, '0);
        tick();
        #1;
        chk("ptr1_grant", DW'(grant),   DW'(1));
        chk("ptr1_data",  m_tdata,      DW'(256'hA1));
        tick();
        clear_inputs();
        tick();

        // input 2 packet under backpressure, input 1 waiting
        da = rnd_d(); db = rnd_d(); dc = rnd_d(); dx = rnd_d();
        drive(2, 1'b1, 1'b0, da, '1, '0);
        drive(1, 1'b1, 1'b1, dx, '1, '0);
        tick();
        #1;
        chk("bp_grant",   DW'(grant),       DW'(2));
        chk("bp_a_data",  m_tdata,          da);
        chk("bp_a_rdy1",  DW'(s_tready[1]), DW'(0));
        tick();
        drive(2, 1'b1, 1'b0, db, '1, '0);
        m_tready = 1'b0;
        #1;
        chk("bp_b_data",  m_tdata,          db);
        chk("bp_b_rdy2",  DW'(s_tready[2]), DW'(0));
        chk("bp_b_rdy1",  DW'(s_tready[1]), DW'(0));
        tick();
        m_tready = 1'b1;
        #1;
        chk("bp_b_held",  m_tdata,          db);
        chk("bp_b_rdy1b", DW'(s_tready[1]), DW'(0));
        tick();
        drive(2, 1'b1, 1'b1, dc, '1, '0);
        #1;
        chk("bp_c_data",  m_tdata,          dc);
        chk("bp_c_tlast", DW'(m_tlast),     DW'(1));
        tick();
        drive(2, 1'b0, 1'b0, '0, '0, '0);
        #1;
        chk("bp_idle_rdy1", DW'(s_tready[1]), DW'(0));
        tick();
        #1;
        chk("bp_g1_grant", DW'(grant),       DW'(1));
        chk("bp_g1_rdy1",  DW'(s_tready[1]), DW'(1));
        chk("bp_g1_data",  m_tdata,          dx);
        tick();
        clear_inputs();
        tick();

        // mid-packet asynchronous reset on input 3
        drive(3, 1'b1, 1'b0, rnd_d(), '1, 128'h0104AAAA);
        tick();
`ifdef ENCAP_ARB_SRC_STAMP_EN
        u_exp = 128'h0140AAAA;
`else
        u_exp = 128'h0104AAAA;
`endif
        #1;
        chk("mr_grant",  DW'(grant),    DW'(3));
        chk("mr_tuser",  DW'(m_tuser),  DW'(u_exp));
        chk("mr_busy",   DW'(busy),     DW'(1));
        tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mr_async_tvalid", DW'(m_tvalid), DW'(0));
        chk("mr_async_busy",   DW'(busy),     DW'(0));
        tick();
        rst_n = 1'b1;

        // all four request single-beat packets continuously
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, rnd_d(), '1, rnd_u());
        gseq = '{0, 1, 2, 3, 0};
        gi   = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            chk("rr_busy", DW'(busy), DW'(c % 2));
            if (busy && gi < 5) begin
                chk("rr_grant", DW'(grant), DW'(gseq[gi]));
                gi++;
            end
            tick();
        end
        chk("rr_count", DW'(gi), DW'(5));
        clear_inputs();
        tick();

        // randomized traffic with random backpressure
        for (int i = 0; i < N; i++) begin
            hold[i] = 0;
            left[i] = 0;
        end
        acc = '0;
        for (int c = 0; c < 3000; c++) begin
            src_step();
            m_tready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
